// File: rtl/immediate_fetcher_pkg.sv
// rtl/immediate_fetcher_pkg.sv - shared types and byte-extension helper for the immediate fetcher
package immediate_fetcher_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Widest operand any instance may assemble; callers truncate to their own width
  localparam int EXT_MAX_BYTES = 8;

  // Keep bytes 0..nbytes-1 of data; fill the rest with the sign of byte nbytes-1 or with zero
  function automatic logic [8*EXT_MAX_BYTES-1:0] extend_bytes(
    input logic [8*EXT_MAX_BYTES-1:0] data,
    input logic [3:0]                 nbytes,
    input logic                       sext
  );
    logic [8*EXT_MAX_BYTES-1:0] res;
    logic [6:0]                 msb;
    logic                       fill;
    res  = '0;
    msb  = {nbytes, 3'b000} - 7'd1;
    fill = sext & (nbytes != 4'd0) & data[msb[5:0]];
    for (int i = 0; i < EXT_MAX_BYTES; i++) begin
      res[8*i +: 8] = (4'(i) < nbytes) ? data[8*i +: 8] : {8{fill}};
    end
    return res;
  endfunction

endpackage

// File: rtl/immediate_fetcher.sv
// rtl/immediate_fetcher.sv - pops 0..MAX_BYTES operand bytes from the prefetch FIFO and extends them
module immediate_fetcher
  import immediate_fetcher_pkg::*;
#(
  parameter  int MAX_BYTES = 4,
  localparam int DATA_W    = 8 * MAX_BYTES,
  localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_bytes,
  input  logic              sign_extend,
  input  logic              abort,
  output logic              busy,
  output logic              complete,
  output logic [DATA_W-1:0] immediate,
  output logic              fifo_rd_en,
  input  logic [7:0]        fifo_rd_data,
  input  logic              fifo_empty
);

  state_t             state;
  logic [CNT_W-1:0]   tgt;
  logic [CNT_W-1:0]   req_cnt;
  logic [CNT_W-1:0]   rcv_cnt;
  logic [CNT_W-1:0]   tgt_new;
  logic [CNT_W-1:0]   rcv_inc;
  logic               sext_q;
  logic               popped;
  logic               accept;
  logic               in_fetch;
  logic [DATA_W-1:0]  asm_q;
  logic [DATA_W-1:0]  asm_next;
  logic [DATA_W-1:0]  ext;
  logic [8*EXT_MAX_BYTES-1:0] wide_asm;
  logic [8*EXT_MAX_BYTES-1:0] wide_ext;

  // Accept decision, clamped byte count, pop request and status outputs
  always_comb begin
    in_fetch   = (state == ST_FETCH);
    accept     = start & ~abort & ~reset & ((state == ST_IDLE) | (state == ST_DONE));
    tgt_new    = (num_bytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : num_bytes;
    // On accept the comparison must use the new target, since tgt is not yet loaded
    fifo_rd_en = ~fifo_empty & ~abort & ~reset &
                 ((accept & (tgt_new != '0)) | (in_fetch & (req_cnt < tgt)));
    busy       = accept | in_fetch;
    complete   = (state == ST_DONE);
  end

  // Next assembly value with the arriving byte in lane rcv_cnt, and its extended form
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (rcv_cnt == CNT_W'(i)) begin
        asm_next[8*i +: 8] = fifo_rd_data;
      end
    end
    rcv_inc  = rcv_cnt + CNT_W'(1);
    wide_asm = '0;
    wide_asm[DATA_W-1:0] = asm_next;
    wide_ext = extend_bytes(wide_asm, 4'(tgt), sext_q);
    ext      = wide_ext[DATA_W-1:0];
  end

  // Sequencer, counters and result register; abort keeps the last result, reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tgt       <= '0;
      req_cnt   <= '0;
      rcv_cnt   <= '0;
      sext_q    <= 1'b0;
      popped    <= 1'b0;
      asm_q     <= '0;
      immediate <= '0;
    end else if (abort) begin
      // A byte popped last cycle lands now and is dropped with the flush
      state  <= ST_IDLE;
      popped <= 1'b0;
    end else begin
      popped <= fifo_rd_en;
      if (accept) begin
        tgt     <= tgt_new;
        sext_q  <= sign_extend;
        req_cnt <= fifo_rd_en ? CNT_W'(1) : '0;
        rcv_cnt <= '0;
        asm_q   <= '0;
        if (tgt_new == '0) begin
          state     <= ST_DONE;
          immediate <= '0;
        end else begin
          state <= ST_FETCH;
        end
      end else begin
        case (state)
          ST_FETCH: begin
            if (fifo_rd_en) begin
              req_cnt <= req_cnt + CNT_W'(1);
            end
            if (popped) begin
              asm_q   <= asm_next;
              rcv_cnt <= rcv_inc;
              if (rcv_inc == tgt) begin
                immediate <= ext;
                state     <= ST_DONE;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
